// File: rtl/and8_exhaustive_tester.sv
// Built-in self-test for an 8-input AND-reduction unit: walks every input vector,
// compares the returned bit against the reduction AND and reports count, first failure and verdict.
//
//   state | meaning
//   IDLE  | waiting for start; results of the last run held
//   HOLD  | vector driven, settle counter running down
//   CHECK | y_in sampled and compared, then advance or finish
//   DONE  | one-cycle completion pulse
module and8_exhaustive_tester #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] vec,
   input  logic             y_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH:0]   err_count,
   output logic [WIDTH-1:0] first_fail,
   output logic             fail_valid
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] settle_cnt;
   logic             mismatch;
   logic             last_vec;
   logic [WIDTH:0]   err_next;

   assign mismatch = (y_in != (&vec));
   assign last_vec = &vec;
   assign err_next = err_count + {{WIDTH{1'b0}}, mismatch};

   // Status flags decode straight from the state so reset clears them at once.
   assign busy = (state == ST_HOLD) || (state == ST_CHECK);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         vec        <= '0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
         fail_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_HOLD;
                  vec        <= '0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  first_fail <= '0;
                  fail_valid <= 1'b0;
                  settle_cnt <= CNT_LOAD;
               end
            end
            ST_HOLD: begin
               if (settle_cnt == '0) state <= ST_CHECK;
               else                  settle_cnt <= settle_cnt - CNT_W'(1);
            end
            ST_CHECK: begin
               err_count <= err_next;
               if (mismatch && !fail_valid) begin
                  first_fail <= vec;
                  fail_valid <= 1'b1;
               end
               // Verdict is registered on entry to DONE so it is already valid during the pulse.
               if (last_vec) begin
                  state <= ST_DONE;
                  pass  <= (err_next == '0);
               end else begin
                  vec        <= vec + WIDTH'(1);
                  settle_cnt <= CNT_LOAD;
                  state      <= ST_HOLD;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/and8_exhaustive_tester.md
# and8_exhaustive_tester

Sequential stimulus generator and checker that drives an 8-input AND-reduction unit. It owns the driving side of that unit's interface: it walks the unit's input vector through every value, samples the unit's single-bit result and compares it with the expected reduction AND. It reports the mismatch count, the first failing vector and a pass/fail verdict. It sits beside the AND-reduction block in the design and acts as a built-in self-test.

## Interface
- WIDTH, 8: width of the driven vector; the block runs 2^WIDTH vectors.
- SETTLE, 1: cycles a vector is held before the result is sampled; legal range is 1 or more.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- vec  out  WIDTH  vector driven to the AND-reduction unit's input.
- y_in  in  1  result returned by the AND-reduction unit.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  verdict of the last completed run; holds until the next start or reset.
- err_count  out  WIDTH+1  number of mismatching vectors in the current or last run.
- first_fail  out  WIDTH  first vector that mismatched.
- fail_valid  out  1  first_fail holds a captured vector.

## Operation
- Reset value of every output is 0: vec, busy, done, pass, err_count, first_fail and fail_valid. The state machine resets to IDLE.
- FSM states:
  - IDLE:
    - start=1 → go to HOLD.
    - On that same edge, clear vec, err_count, pass, first_fail and fail_valid.
    - Load the settle counter with SETTLE-1.
  - HOLD:
    - vec is stable.
    - The counter decrements each cycle.
    - When the counter is 0 → go to CHECK.
  - CHECK:
    - Compute expected = &vec.
    - If y_in != expected:
      - Increment err_count.
      - If fail_valid=0, capture vec into first_fail and set fail_valid=1.
    - If vec is all-ones → go to DONE.
    - Otherwise increment vec, reload the counter and go to HOLD.
  - DONE:
    - Assert done for one cycle.
    - Set pass to 1 if err_count is 0, else 0.
    - Go to IDLE.
- busy is 1 in HOLD and CHECK, and 0 in IDLE and DONE.
- start is ignored outside IDLE, including in DONE.
- vec does not wrap. The run ends at all-ones, and vec holds all-ones until the next start.
- err_count is WIDTH+1 bits so it can hold 2^WIDTH without overflow. No saturation logic is needed.
- The mismatch test and the first-fail capture happen on the same edge. The first mismatch therefore makes err_count 1 and fail_valid 1 simultaneously.
- Reset mid-run forces IDLE and all outputs to 0 immediately, with no done pulse. A later start performs a full run from vector 0.

## Timing
- Edge where start is sampled in IDLE: vec becomes 0 and busy becomes 1 in the following cycle.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in HOLD, then 1 cycle in CHECK.
- y_in is sampled at the end of the CHECK cycle, which is the (SETTLE+1)th cycle that the vector is driven. The AND-reduction unit may therefore have up to SETTLE cycles of combinational or registered latency.
- A full run lasts 2^WIDTH·(SETTLE+1) busy cycles. The DONE cycle follows, and IDLE follows that.
- Defaults: 512 busy cycles, with done asserted in cycle 513 after the start edge.
- pass, err_count, first_fail and fail_valid update no later than the DONE cycle. They remain stable in IDLE.

## Test plan
- Ideal unit (y_in = &vec, combinational), start pulse: vec steps 0x00..0xFF every 2 cycles; done pulses once, 513 cycles after start; pass=1, err_count=0, fail_valid=0.
- y_in stuck at 0: err_count=1, first_fail=0xFF, fail_valid=1, pass=0.
- y_in stuck at 1: err_count=255, first_fail=0x00, pass=0.
- start re-pulsed while busy (at vector 0x20), and again in the DONE cycle: both pulses ignored; exactly one done pulse; run length unchanged.
- rst asserted asynchronously while vec=0x40: all outputs 0 immediately with no done pulse. A new start then gives a full 256-vector run with pass=1.
- SETTLE=3, unit with a 3-cycle registered delay: pass=1 and done 1025 cycles after start. Repeat with a 4-cycle delay: pass=0 and err_count>0.
